rv32_fetch: RTL and testbench

RV32_FETCH -- requirements
Module: rv32_fetch

---
 rtl/rv32_fetch_pkg.sv | 20 ++
 rtl/rv32_fetch_fifo.sv | 74 +++++++
 rtl/rv32_fetch.sv | 122 ++++++++++++
 tb/tb_rv32_fetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_fetch_pkg.sv
// rv32_fetch_pkg
// Shared RV32 types for the fetch stage and its instruction buffer.
//   rv_pc_cnt_t    : 32-bit program counter / byte address
//   rv32_instr_t   : 32-bit raw instruction word
//   RV32_NOP       : canonical NOP (addi x0, x0, 0), shown when nothing is valid
//   rv32_align_pc  : clears the two byte-offset bits of an address
package rv32_fetch_pkg;

    typedef logic [31:0] rv_pc_cnt_t;
    typedef logic [31:0] rv32_instr_t;

    localparam rv32_instr_t RV32_NOP = 32'h0000_0013;

    // Instruction fetches are always word aligned, so the low two bits are
    // forced to zero rather than trusted from whoever produced the address.
    function automatic rv_pc_cnt_t rv32_align_pc(input rv_pc_cnt_t addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/rv32_fetch_fifo.sv
// rv32_fetch_fifo
// Two-entry buffer of {pc, instr} pairs sitting between instruction memory
// and the decoder.
//   clk, rst        : clock, synchronous active-high reset
//   push_i          : write {push_pc_i, push_instr_i} at the tail
//   pop_i           : drop the head entry
//   flush_i         : discard every entry (takes priority over push/pop)
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored entries (0..2)
//   head_pc_o       : pc of the oldest entry (undefined content when empty)
//   head_instr_o    : instruction of the oldest entry
module rv32_fetch_fifo
    import rv32_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [31:0] push_pc_i,
    input  logic [31:0] push_instr_i,
    output logic        full_o,
    output logic        empty_o,
    output logic [1:0]  count_o,
    output logic [31:0] head_pc_o,
    output logic [31:0] head_instr_o
);

    rv_pc_cnt_t  pcMem_q    [2];
    rv32_instr_t instrMem_q [2];
    logic        wrPtr_q;
    logic        rdPtr_q;
    logic [1:0]  count_q;

    logic        pushEn;
    logic        popEn;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

    // A push into a full buffer is only legal when the head leaves in the
    // same cycle; in that case the slot being written is the one being freed.
    assign pushEn = push_i & (~full_o | pop_i);
    assign popEn  = pop_i & ~empty_o;

    assign head_pc_o    = pcMem_q[rdPtr_q];
    assign head_instr_o = instrMem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= ~wrPtr_q;
            end
            if (popEn) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_q + {1'b0, pushEn} - {1'b0, popEn};
        end
    end

    // Storage needs no reset: entries are only observable through count_q.
    always_ff @(posedge clk) begin
        if (pushEn && !rst && !flush_i) begin
            pcMem_q[wrPtr_q]    <= push_pc_i;
            instrMem_q[wrPtr_q] <= push_instr_i;
        end
    end

endmodule

// File: rtl/rv32_fetch.sv
// rv32_fetch
// RV32 instruction fetch stage: walks a word-aligned PC, issues reads to a
// single-cycle-latency instruction memory, buffers the responses and hands
// {instr, pc} to the decoder with a valid/ready handshake.
//   clk, rst                    : clock, synchronous active-high reset
//   fetch_en                    : fetching allowed while high
//   redirect_valid, redirect_pc : change of flow; flushes buffered/in-flight work
//   imem_req, imem_addr         : memory read strobe and word address
//   imem_rdata                  : read data, valid one cycle after imem_req
//   instr, pc, instr_valid      : instruction to the decoder (NOP/0 when idle)
//   instr_ready                 : decoder accepts instr this cycle
module rv32_fetch
    import rv32_fetch_pkg::*;
#(
    parameter rv_pc_cnt_t RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  rv_pc_cnt_t  redirect_pc,
    output logic        imem_req,
    output rv_pc_cnt_t  imem_addr,
    input  rv32_instr_t imem_rdata,
    output rv32_instr_t instr,
    output rv_pc_cnt_t  pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    fetch_state_t state_q;
    rv_pc_cnt_t   pc_q;
    rv_pc_cnt_t   pc_d;
    rv_pc_cnt_t   reqPc_q;
    logic         inflight_q;

    logic         fifoPush;
    logic         fifoFlush;
    logic         fifoFull;
    logic         fifoEmpty;
    logic [1:0]   fifoCount;
    rv_pc_cnt_t   fifoHeadPc;
    rv32_instr_t  fifoHeadInstr;

    logic         instrPop;
    logic [2:0]   occupancy;
    logic         roomForReq;

    assign instr_valid = ~fifoEmpty;
    assign instrPop    = instr_valid & instr_ready;
    assign instr       = instr_valid ? fifoHeadInstr : RV32_NOP;
    assign pc          = instr_valid ? fifoHeadPc    : '0;
    assign imem_addr   = pc_q;

    // Buffered entries plus the response arriving this cycle must still fit
    // in two slots after this cycle's pop, otherwise a new response could
    // land on a full buffer. A full buffer needs a pop and no arrival.
    assign occupancy  = {1'b0, fifoCount} + {2'b00, inflight_q};
    assign roomForReq = fifoFull ? (instrPop & ~inflight_q)
                                 : (occupancy < (3'd2 + {2'b00, instrPop}));

    // Kept combinational because the issue decision depends on this cycle's
    // decoder handshake; gating with fetch_en stops issue in the very cycle
    // fetching is withdrawn instead of one cycle later.
    assign imem_req = ~rst & (state_q == RUN) & fetch_en & ~redirect_valid & roomForReq;

    // inflight_q marks that imem_rdata carries our response this cycle; a
    // redirect makes that response stale, so it is simply not written.
    assign fifoPush  = inflight_q & ~redirect_valid & ~rst;
    assign fifoFlush = redirect_valid & ~rst;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = rv32_align_pc(redirect_pc);
        end else if (imem_req) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= rv32_align_pc(RESET_PC);
            reqPc_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (fetch_en)  state_q <= RUN;
                RUN:     if (!fetch_en) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            pc_q       <= pc_d;
            inflight_q <= imem_req;
            if (imem_req) begin
                reqPc_q <= pc_q;
            end
        end
    end

    rv32_fetch_fifo u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (fifoPush),
        .pop_i        (instrPop),
        .flush_i      (fifoFlush),
        .push_pc_i    (reqPc_q),
        .push_instr_i (imem_rdata),
        .full_o       (fifoFull),
        .empty_o      (fifoEmpty),
        .count_o      (fifoCount),
        .head_pc_o    (fifoHeadPc),
        .head_instr_o (fifoHeadInstr)
    );

endmodule

// File: tb/tb_rv32_fetch.sv
// tb_rv32_fetch
// Directed, table-driven bench for rv32_fetch. Each vector is one clock
// cycle: inputs are driven just after a rising edge, outputs are compared a
// moment later, then the clock advances. A small memory model returns a
// data word derived from the address so every delivered instr can be tied
// back to its pc.
module tb_rv32_fetch;
    import rv32_fetch_pkg::*;

    localparam rv_pc_cnt_t TB_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    rv_pc_cnt_t  redirect_pc;
    logic        imem_req;
    rv_pc_cnt_t  imem_addr;
    rv32_instr_t imem_rdata;
    rv32_instr_t instr;
    rv_pc_cnt_t  pc;
    logic        instr_valid;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic        redir;
        logic [31:0] redirPc;
        logic        ready;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rv32_fetch #(.RESET_PC(TB_RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .pc             (pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
    );

    function automatic logic [31:0] instrOf(input logic [31:0] addr);
        return addr ^ 32'hA5C3_0F00;
    endfunction

    // Single-cycle memory: data for an accepted request appears next cycle.
    logic [31:0] memData = '0;
    always @(posedge clk) begin
        if (imem_req) memData <= instrOf(imem_addr);
    end
    assign imem_rdata = memData;

    function automatic vec_t mk(input logic r, input logic e, input logic rd,
                                input logic [31:0] rpc, input logic rdy,
                                input logic xReq, input logic [31:0] xAddr,
                                input logic xValid, input logic [31:0] xPc);
        vec_t v;
        v.rst = r;  v.en = e;  v.redir = rd;  v.redirPc = rpc;  v.ready = rdy;
        v.expReq = xReq;  v.expAddr = xAddr;  v.expValid = xValid;  v.expPc = xPc;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        fetch_en       = v.en;
        redirect_valid = v.redir;
        redirect_pc    = v.redirPc;
        instr_ready    = v.ready;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkVector(input string tag, input vec_t v);
        logic [31:0] expInstr;
        expInstr = v.expValid ? instrOf(v.expPc) : RV32_NOP;
        checkOutput({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, v.expReq});
        if (v.expReq) checkOutput({tag, " imem_addr"}, imem_addr, v.expAddr);
        checkOutput({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, v.expValid});
        checkOutput({tag, " pc"}, pc, v.expPc);
        checkOutput({tag, " instr"}, instr, expInstr);
    endtask

    task automatic runCycle(input string tag, input vec_t v);
        applyStimulus(v);
        checkVector(tag, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("reset imem_req", {31'b0, imem_req}, 32'd0);
        checkOutput("reset instr_valid", {31'b0, instr_valid}, 32'd0);
        checkOutput("reset instr", instr, 32'h0000_0013);
        checkOutput("reset pc", pc, 32'd0);

        //               rst en rd redirPc       rdy req addr          val pc
        // start-up stream from RESET_PC
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  0, 32'h0,         0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h100,       0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h104,       0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h108,       1, 32'h100));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h10C,       1, 32'h104));
        // decoder stalls three cycles: buffer fills, requests stop, head held
        vecs.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1, 32'h108));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1, 32'h108));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0,  0, 32'h0,         1, 32'h108));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h110,       1, 32'h108));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h114,       1, 32'h10C));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h118,       1, 32'h110));
        // fetch_en dropped with one request in flight, then re-enabled
        vecs.push_back(mk(0, 0, 0, 32'h0,        1,  0, 32'h0,         1, 32'h114));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1,  0, 32'h0,         1, 32'h118));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1,  0, 32'h0,         0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  0, 32'h0,         0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h11C,       0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h120,       0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h124,       1, 32'h11C));
        // redirect to unaligned 0x2003 while 0x124 is in flight
        vecs.push_back(mk(0, 1, 1, 32'h2003,     1,  0, 32'h0,         1, 32'h120));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h2000,      0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h2004,      0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h2008,      1, 32'h2000));
        // redirect to the top of the address space, pc wraps to zero
        vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFF, 1,  0, 32'h0,         1, 32'h2004));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'hFFFFFFFC,  0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h0,         0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h4,         1, 32'hFFFFFFFC));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h8,         1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'hC,         1, 32'h4));
        // reset with a response arriving; redirect during reset is ignored
        vecs.push_back(mk(1, 1, 1, 32'h5000,     0,  0, 32'h0,         1, 32'h8));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  0, 32'h0,         0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h100,       0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h104,       0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1,  1, 32'h108,       1, 32'h100));

        foreach (vecs[i]) begin
            runCycle($sformatf("v%0d", i), vecs[i]);
        end

        // Buffer completely full, then reset: nothing survives, restart at RESET_PC.
        runCycle("fullA1", mk(0, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'h104));
        runCycle("fullA2", mk(0, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'h104));
        runCycle("fullA3", mk(1, 1, 0, 32'h0, 0, 0, 32'h0,   1, 32'h104));
        runCycle("fullA4", mk(0, 1, 0, 32'h0, 1, 0, 32'h0,   0, 32'h0));
        runCycle("fullA5", mk(0, 1, 0, 32'h0, 1, 1, 32'h100, 0, 32'h0));

        // Redirect accepted while IDLE; fetch resumes at the target on enable.
        runCycle("idleB1", mk(0, 0, 0, 32'h0,    1, 0, 32'h0,    0, 32'h0));
        runCycle("idleB2", mk(0, 0, 1, 32'h3001, 1, 0, 32'h0,    1, 32'h100));
        runCycle("idleB3", mk(0, 0, 0, 32'h0,    1, 0, 32'h0,    0, 32'h0));
        runCycle("idleB4", mk(0, 1, 0, 32'h0,    1, 0, 32'h0,    0, 32'h0));
        runCycle("idleB5", mk(0, 1, 0, 32'h0,    1, 1, 32'h3000, 0, 32'h0));
        runCycle("idleB6", mk(0, 1, 0, 32'h0,    1, 1, 32'h3004, 0, 32'h0));
        runCycle("idleB7", mk(0, 1, 0, 32'h0,    1, 1, 32'h3008, 1, 32'h3000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
